// File: rtl/wand_bus_tx_arb_if.sv
// rtl/wand_bus_tx_arb_if.sv - request/line interface of the wired-AND transmitter
interface wand_bus_tx_arb_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              bus_in;
    logic              bus_oe;
    logic              busy;
    logic              done;
    logic              lost;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output start, tx_data, bus_in,
        input  bus_oe, busy, done, lost, rx_data
    );

    modport slave (
        input  start, tx_data, bus_in,
        output bus_oe, busy, done, lost, rx_data
    );
endinterface

// File: rtl/wand_bus_tx_arb.sv
// rtl/wand_bus_tx_arb.sv - open-drain framed transmitter with wired-AND arbitration
module wand_bus_tx_arb #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    wand_bus_tx_arb_if.slave bus
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [DATA_W-1:0] MASK_MSB = DATA_W'(1) << (DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [CW-1:0]     cyc_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_mask;
    logic [DATA_W-1:0] tx_shift_next;
    logic              bit_last;
    logic              line_hi;

    // Only a clean 1 means the line is released; x and z are treated as pulled low.
    assign line_hi       = (bus.bus_in === 1'b1);
    assign bit_last      = (cyc_cnt == CW'(BIT_CYCLES - 1));
    assign tx_shift_next = tx_shift << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            tx_shift    <= '0;
            rx_mask     <= '0;
            bus.bus_oe  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.lost    <= 1'b0;
            bus.rx_data <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.lost <= 1'b0;
            cyc_cnt  <= bit_last ? '0 : cyc_cnt + 1'b1;
            case (state)
                IDLE: begin
                    cyc_cnt <= '0;
                    if (bus.start && line_hi) begin
                        state       <= START;
                        tx_shift    <= bus.tx_data;
                        rx_mask     <= MASK_MSB;
                        bus.rx_data <= '0;
                        bus.busy    <= 1'b1;
                        bus.bus_oe  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_last) begin
                        state      <= DATA;
                        bus.bus_oe <= ~tx_shift[DATA_W-1];
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        if (line_hi) begin
                            bus.rx_data <= bus.rx_data | rx_mask;
                        end
                        // Released the line but someone else held it low: back off now.
                        if (tx_shift[DATA_W-1] && !line_hi) begin
                            state      <= IDLE;
                            bus.bus_oe <= 1'b0;
                            bus.busy   <= 1'b0;
                            bus.lost   <= 1'b1;
                        end else if (rx_mask[0]) begin
                            state      <= STOP;
                            bus.bus_oe <= 1'b0;
                        end else begin
                            tx_shift   <= tx_shift_next;
                            rx_mask    <= rx_mask >> 1;
                            bus.bus_oe <= ~tx_shift_next[DATA_W-1];
                        end
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        state      <= IDLE;
                        bus.bus_oe <= 1'b0;
                        bus.busy   <= 1'b0;
                        bus.done   <= line_hi;
                        bus.lost   <= ~line_hi;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.bus_oe <= 1'b0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wand_bus_tx_arb.sv
// tb/tb_wand_bus_tx_arb.sv - table, hand-sequence and random checks of wand_bus_tx_arb
module tb_wand_bus_tx_arb;
    localparam int DW   = 8;
    localparam int BC   = 4;
    localparam int NB   = DW + 2;
    localparam int NCYC = NB * BC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic comp_low = 1'b0;
    logic z_now = 1'b0;
    int   checks = 0;
    int   errors = 0;

    wand_bus_tx_arb_if #(.DATA_W(DW)) bif ();

    wand_bus_tx_arb #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    always #5 clk = ~clk;

    // Wired-AND line: pull-up, our driver, the competitor; z injected on request.
    always_comb begin
        bif.bus_in = 1'b0;
        if (z_now) bif.bus_in = 1'bz;
        else       bif.bus_in = !(bif.bus_oe || comp_low);
    end

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] comp;
        bit            active;
        bit            stop_low;
        int            zbit;
        int            loss_bit;
        logic [DW-1:0] exp_rx;
        string         name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic fbit(input logic [DW-1:0] v, input int b);
        logic [DW-1:0] t;
        if (b == 0) return 1'b0;
        if (b > DW) return 1'b1;
        t = v >> (DW - b);
        return t[0];
    endfunction

    // Outcome of a frame from the line rules: resolved bit = AND of all drivers.
    task automatic predict(input logic [DW-1:0] tx, input logic [DW-1:0] comp, input bit active,
                           input bit stop_low, input int zbit, output int loss, output logic [DW-1:0] rx);
        logic r;
        loss = -1;
        rx   = '0;
        for (int b = 1; b < NB; b++) begin
            if (loss < 0) begin
                r = fbit(tx, b) & (active ? fbit(comp, b) : 1'b1)
                    & !(stop_low && b == NB - 1) & (b != zbit);
                if (b <= DW) rx = (rx << 1) | DW'(r);
                if (fbit(tx, b) && !r) begin
                    loss = b;
                    if (b <= DW) rx = rx << (DW - b);
                end
            end
        end
    endtask

    task automatic run_frame(input vec_t v);
        int end_k, oe_err, busy_err, lost_err, done_err, b;
        logic exp_oe;
        oe_err = 0; busy_err = 0; lost_err = 0; done_err = 0;
        end_k = (v.loss_bit >= 0) ? (v.loss_bit + 1) * BC + 1 : NCYC + 1;
        @(negedge clk);
        bif.tx_data = v.tx;
        bif.start   = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        for (int k = 1; k <= NCYC + 2; k++) begin
            b = (k - 1) / BC;
            comp_low = (v.active && b < NB && !fbit(v.comp, b)) || (v.stop_low && b == NB - 1);
            z_now    = (b == v.zbit);
            exp_oe   = (k < end_k) ? !fbit(v.tx, b) : 1'b0;
            if (bif.bus_oe !== exp_oe) oe_err++;
            if (bif.busy !== (k < end_k)) busy_err++;
            if (bif.lost !== (v.loss_bit >= 0 && k == end_k)) lost_err++;
            if (bif.done !== (v.loss_bit < 0 && k == end_k)) done_err++;
            if (bif.done === 1'b1 && bif.lost === 1'b1) done_err++;
            @(negedge clk);
        end
        comp_low = 1'b0;
        z_now    = 1'b0;
        check({v.name, " bus_oe_trace"}, oe_err, 0);
        check({v.name, " busy"}, busy_err, 0);
        check({v.name, " lost_timing"}, lost_err, 0);
        check({v.name, " done_timing"}, done_err, 0);
        check({v.name, " rx_data"}, bif.rx_data, v.exp_rx);
    endtask

    vec_t vecs[5];
    vec_t rv;
    int   bad, n;

    initial begin
        vecs[0] = '{8'hA5, 8'h00, 1'b0, 1'b0, -1, -1, 8'hA5, "solo_a5"};
        vecs[1] = '{8'hA5, 8'hA1, 1'b1, 1'b0, -1,  6, 8'hA0, "lose_a5_a1"};
        vecs[2] = '{8'hA1, 8'hA5, 1'b1, 1'b0, -1, -1, 8'hA1, "win_a1_a5"};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b0,  3,  3, 8'hC0, "z_on_data"};
        vecs[4] = '{8'h3C, 8'h00, 1'b0, 1'b1, -1,  9, 8'h3C, "stop_low"};

        bif.start   = 1'b0;
        bif.tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset bus_oe", bif.bus_oe, 0);
        check("reset busy", bif.busy, 0);
        check("reset done", bif.done, 0);
        check("reset lost", bif.lost, 0);
        check("reset rx_data", bif.rx_data, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_frame(vecs[i]);

        // Start while another driver holds the line low is ignored.
        bad = 0;
        comp_low    = 1'b1;
        bif.start   = 1'b1;
        bif.tx_data = 8'h55;
        repeat (4) begin
            @(negedge clk);
            if (bif.busy !== 1'b0 || bif.bus_oe !== 1'b0) bad++;
        end
        bif.start = 1'b0;
        comp_low  = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_line ignored", bad, 0);
        check("busy_line idle after", bif.busy, 0);

        // Reset in cycle 15 of a frame.
        bif.tx_data = 8'h00;
        bif.start   = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (14) @(negedge clk);
        check("midreset busy before", bif.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset bus_oe", bif.bus_oe, 0);
        check("midreset busy", bif.busy, 0);
        check("midreset rx_data", bif.rx_data, 0);
        bad = 0;
        repeat (NCYC + 4) begin
            if (bif.done !== 1'b0 || bif.lost !== 1'b0 || bif.bus_oe !== 1'b0) bad++;
            @(negedge clk);
        end
        check("midreset no pulse", bad, 0);

        // Back-to-back: start held through the done cycle.
        bif.tx_data = 8'h5A;
        bif.start   = 1'b1;
        n = 0;
        @(negedge clk);
        @(negedge clk);
        bif.tx_data = 8'h3C;
        while (bif.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b first done cycle", n + 2, NCYC + 1);
        check("b2b first rx_data", bif.rx_data, 8'h5A);
        @(negedge clk);
        bif.start = 1'b0;
        check("b2b second bus_oe", bif.bus_oe, 1);
        check("b2b second busy", bif.busy, 1);
        n = 0;
        while (bif.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b second done", bif.done, 1);
        check("b2b second rx_data", bif.rx_data, 8'h3C);
        repeat (2) @(negedge clk);

        // Randomized frames against the line model.
        for (int i = 0; i < 20; i++) begin
            rv.tx       = DW'($urandom);
            rv.comp     = DW'($urandom);
            rv.active   = $urandom_range(0, 1) == 1;
            rv.stop_low = $urandom_range(0, 7) == 0;
            rv.zbit     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, NB - 1)) : -1;
            rv.name     = $sformatf("rand%0d", i);
            predict(rv.tx, rv.comp, rv.active, rv.stop_low, rv.zbit, rv.loss_bit, rv.exp_rx);
            run_frame(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
